// File: rtl/ram_ctrl_pkg.sv
// Shared types and command opcodes for the command-RAM scheduler.
// The RAM takes two 10-bit words per transaction: {opcode, payload}.
package ram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        DATA    = 3'd2,
        WAIT_RD = 3'd3,
        RESP    = 3'd4
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on contention the requester that did not win
// last time gets the grant; a lone requester always wins.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (valid == 2'b11) begin
            gnt = last_grant ? 2'b01 : 2'b10;
        end else begin
            gnt = valid;
        end
    end

endmodule

// File: rtl/ram_cmd_arbiter.sv
// Two-master scheduler for the single-port command RAM: arbitrates, emits the
// two-word command, waits for read data (with timeout) and returns a response.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | offer ready to the arbiter winner, latch txn on handshake
//   ADDR    | drive address command word
//   DATA    | drive data command word (reads: clear timer)
//   WAIT_RD | wait for ram_tx_valid or timeout
//   RESP    | one-cycle response pulse to the granted master
module ram_cmd_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,

    output logic [9:0]        ram_din,
    output logic              ram_rx_valid,
    input  logic [7:0]        ram_dout,
    input  logic              ram_tx_valid
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic              last_grant;
    logic              txn_grant;
    logic              txn_write;
    logic [ADDR_W-1:0] txn_addr;
    logic [DATA_W-1:0] txn_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [TW-1:0]     timer;
    logic [1:0]        gnt;
    logic              any_gnt;

    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

    assign any_gnt = |gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        ram_din      = 10'h000;
        ram_rx_valid = 1'b0;
        rsp0_valid   = 1'b0;
        rsp1_valid   = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = gnt[0];
                req1_ready = gnt[1];
                if (any_gnt) state_nxt = ADDR;
            end
            ADDR: begin
                ram_rx_valid = 1'b1;
                ram_din      = {txn_write ? CMD_WR_ADDR : CMD_RD_ADDR, txn_addr};
                state_nxt    = DATA;
            end
            DATA: begin
                ram_rx_valid = 1'b1;
                ram_din      = {txn_write ? CMD_WR_DATA : CMD_RD_DATA,
                                txn_write ? txn_wdata : {DATA_W{1'b0}}};
                state_nxt    = txn_write ? RESP : WAIT_RD;
            end
            WAIT_RD: begin
                if (ram_tx_valid || timer == T_LAST) state_nxt = RESP;
            end
            RESP: begin
                rsp0_valid = !txn_grant;
                rsp1_valid = txn_grant;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            txn_grant  <= 1'b0;
            txn_write  <= 1'b0;
            txn_addr   <= '0;
            txn_wdata  <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            timer      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_gnt) begin
                        txn_grant <= gnt[1];
                        txn_write <= gnt[1] ? req1_write : req0_write;
                        txn_addr  <= gnt[1] ? req1_addr  : req0_addr;
                        txn_wdata <= gnt[1] ? req1_wdata : req0_wdata;
                        rdata_q   <= '0;
                        err_q     <= 1'b0;
                    end
                end
                DATA: begin
                    if (!txn_write) timer <= '0;
                end
                WAIT_RD: begin
                    if (ram_tx_valid) begin
                        rdata_q <= ram_dout;
                        err_q   <= 1'b0;
                    end else if (timer == T_LAST) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    last_grant <= txn_grant;
                end
                default: ;
            endcase
        end
    end

    // Response data is only visible during the pulse; idle ports read as 0.
    assign rsp0_rdata = rsp0_valid ? rdata_q : '0;
    assign rsp0_err   = rsp0_valid & err_q;
    assign rsp1_rdata = rsp1_valid ? rdata_q : '0;
    assign rsp1_err   = rsp1_valid & err_q;

endmodule
